mac_nibble_feeder: RTL and testbench

Host-side driver for the nibble-serial dot-product MAC tile. It accepts 16-bit weight or input words over a valid/ready command port and shifts each word out as four 4-bit nibbles, least-significant nibble first, with a weight/input select line. On request it waits a fixed settle time, samples the tile's 10-bit running-max result, and returns it on a valid/ready response port. It sits between the test/host logic and the MAC tile's ui_in/uio pins.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_nibble_feeder.sv | 118 +++++++++++
 tb/tb_mac_nibble_feeder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the nibble-serial MAC tile host interface.
// Word geometry, feeder state encoding and weight/input select values.
package mac_pkg;

    localparam int NIB_W  = 4;
    localparam int LANES  = 4;
    localparam int WORD_W = NIB_W * LANES;
    localparam int RES_W  = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_SETTLE,
        S_RESP
    } feeder_state_e;

    localparam logic SEL_WEIGHTS = 1'b1;
    localparam logic SEL_INPUTS  = 1'b0;

endpackage

// File: rtl/mac_nibble_feeder.sv
// Host-side feeder: serialises 16-bit words into LSB-first nibbles for the MAC
// tile and optionally captures the tile's running-max result after a settle delay.
module mac_nibble_feeder
    import mac_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sel,
    input  logic             cmd_capture,
    input  logic [WORD_W-1:0] cmd_data,
    output logic [NIB_W-1:0] nib_out,
    output logic             nib_sel,
    output logic             nib_valid,
    input  logic [RES_W-1:0] res_in,
    output logic             res_valid,
    output logic [RES_W-1:0] res_data,
    input  logic             res_ready,
    output logic             busy
);

    localparam logic [1:0] LAST_IDX    = 2'(LANES - 1);
    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE - 1);

    feeder_state_e     r_state;
    feeder_state_e     w_next_state;
    logic [WORD_W-1:0] r_word;
    logic              r_capture;
    logic [1:0]        r_idx;
    logic [7:0]        r_cnt;
    logic [NIB_W-1:0]  r_nib_out;
    logic              r_nib_sel;
    logic              r_nib_valid;
    logic              r_res_valid;
    logic [RES_W-1:0]  r_res_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (cmd_valid) w_next_state = S_SHIFT;
            S_SHIFT:  if (r_idx == LAST_IDX) w_next_state = r_capture ? S_SETTLE : S_IDLE;
            S_SETTLE: if (r_cnt == 8'd0) w_next_state = S_RESP;
            S_RESP:   if (res_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // r_word is a shift register: the next nibble to present always sits in bits [7:4].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word      <= '0;
            r_capture   <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_nib_out   <= '0;
            r_nib_sel   <= 1'b0;
            r_nib_valid <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_word      <= cmd_data;
                        r_capture   <= cmd_capture;
                        r_idx       <= '0;
                        r_nib_out   <= cmd_data[NIB_W-1:0];
                        r_nib_sel   <= cmd_sel;
                        r_nib_valid <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_idx == LAST_IDX) begin
                        r_nib_valid <= 1'b0;
                        r_nib_out   <= '0;
                        r_cnt       <= SETTLE_INIT;
                    end else begin
                        r_idx     <= r_idx + 2'd1;
                        r_nib_out <= r_word[2*NIB_W-1 -: NIB_W];
                        r_word    <= r_word >> NIB_W;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 8'd0) begin
                        r_res_data  <= res_in;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    if (res_ready) r_res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign nib_out   = r_nib_out;
    assign nib_sel   = r_nib_sel;
    assign nib_valid = r_nib_valid;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_mac_nibble_feeder.sv
// Self-checking bench for mac_nibble_feeder: directed test-plan steps plus
// random words, checked against an arithmetic model of the nibble/result timing.
module tb_mac_nibble_feeder;
    import mac_pkg::*;

    localparam int SETTLE_TB = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_sel;
    logic              cmd_capture;
    logic [WORD_W-1:0] cmd_data;
    logic [NIB_W-1:0]  nib_out;
    logic              nib_sel;
    logic              nib_valid;
    logic [RES_W-1:0]  res_in;
    logic              res_valid;
    logic [RES_W-1:0]  res_data;
    logic              res_ready;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    mac_nibble_feeder #(.SETTLE(SETTLE_TB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_sel     (cmd_sel),
        .cmd_capture (cmd_capture),
        .cmd_data    (cmd_data),
        .nib_out     (nib_out),
        .nib_sel     (nib_sel),
        .nib_valid   (nib_valid),
        .res_in      (res_in),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full command transaction; expectations come from the word's arithmetic
    // nibble decomposition and the documented cycle timing.
    task automatic applyStimulus(input logic sel, input logic [15:0] data,
                                 input logic capture, input logic [9:0] resVal,
                                 input int readyDelay, input logic pokeBusy);
        logic [3:0] expNib;
        @(negedge clk);
        checkOutput("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_sel     = sel;
        cmd_data    = data;
        cmd_capture = capture;
        res_in      = resVal;
        for (int k = 0; k < LANES; k++) begin
            @(negedge clk);
            if (pokeBusy) begin
                cmd_valid = 1'b1;
                cmd_data  = 16'hFFFF;
                cmd_sel   = ~sel;
            end else begin
                cmd_valid = 1'b0;
                cmd_data  = 16'($urandom);
            end
            expNib = 4'((data >> (4 * k)) % 16);
            checkOutput("nib_valid", 32'(nib_valid), 32'd1);
            checkOutput("nib_out", 32'(nib_out), 32'(expNib));
            checkOutput("nib_sel", 32'(nib_sel), 32'(sel));
            checkOutput("shift_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("nib_valid_fall", 32'(nib_valid), 32'd0);
        checkOutput("nib_out_zero", 32'(nib_out), 32'd0);
        if (!capture) begin
            checkOutput("post_cmd_ready", 32'(cmd_ready), 32'd1);
            checkOutput("post_busy", 32'(busy), 32'd0);
        end else begin
            checkOutput("settle_res_valid", 32'(res_valid), 32'd0);
            for (int i = 1; i < SETTLE_TB; i++) begin
                @(negedge clk);
                checkOutput("settle_res_valid", 32'(res_valid), 32'd0);
            end
            @(negedge clk);
            checkOutput("res_valid_rise", 32'(res_valid), 32'd1);
            checkOutput("res_data", 32'(res_data), 32'(resVal));
            res_in = 10'(resVal ^ 10'h3FF);
            for (int i = 0; i < readyDelay; i++) begin
                @(negedge clk);
                checkOutput("hold_res_valid", 32'(res_valid), 32'd1);
                checkOutput("hold_res_data", 32'(res_data), 32'(resVal));
                checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            checkOutput("res_valid_fall", 32'(res_valid), 32'd0);
            checkOutput("res_data_kept", 32'(res_data), 32'(resVal));
            checkOutput("resp_cmd_ready", 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        logic        rSel;
        logic        rCap;
        logic [15:0] rData;
        logic [9:0]  rRes;
        int          rDelay;

        rst_n       = 1'b0;
        cmd_valid   = 1'b1;
        cmd_sel     = SEL_WEIGHTS;
        cmd_capture = 1'b0;
        cmd_data    = 16'hBEEF;
        res_in      = '0;
        res_ready   = 1'b0;

        $display("[TB] reset with cmd_valid held high");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_nib_valid", 32'(nib_valid), 32'd0);
            checkOutput("rst_nib_out", 32'(nib_out), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
            checkOutput("rst_res_data", 32'(res_data), 32'd0);
        end
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        checkOutput("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rel_nib_valid", 32'(nib_valid), 32'd0);

        $display("[TB] weight word A5C3");
        applyStimulus(SEL_WEIGHTS, 16'hA5C3, 1'b0, 10'h000, 0, 1'b0);

        $display("[TB] input word 1234 with capture");
        applyStimulus(SEL_INPUTS, 16'h1234, 1'b1, 10'h2D1, 0, 1'b0);

        $display("[TB] backpressure on result");
        applyStimulus(SEL_INPUTS, 16'h1234, 1'b1, 10'h2D1, 10, 1'b0);

        $display("[TB] command offered during shift");
        applyStimulus(SEL_WEIGHTS, 16'h0000, 1'b0, 10'h000, 0, 1'b1);
        applyStimulus(SEL_INPUTS, 16'hFFFF, 1'b0, 10'h000, 0, 1'b0);

        $display("[TB] reset mid-shift");
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_sel     = SEL_WEIGHTS;
        cmd_data    = 16'h9876;
        cmd_capture = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("abort_nib0", 32'(nib_out), 32'h6);
        @(negedge clk);
        checkOutput("abort_nib1", 32'(nib_out), 32'h7);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_nib_valid", 32'(nib_valid), 32'd0);
        checkOutput("abort_nib_out", 32'(nib_out), 32'd0);
        checkOutput("abort_nib_sel", 32'(nib_sel), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(SEL_INPUTS, 16'h0001, 1'b0, 10'h000, 0, 1'b0);

        $display("[TB] random words");
        for (int n = 0; n < 12; n++) begin
            rSel   = 1'($urandom);
            rCap   = 1'($urandom);
            rData  = 16'($urandom);
            rRes   = 10'($urandom);
            rDelay = int'($urandom_range(0, 3));
            applyStimulus(rSel, rData, rCap, rRes, rDelay, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
